// File: rtl/pipe_hazard_ctl_if.sv
// Pipeline hazard bus: the ID/EX hazard inputs and the per-register hold/bubble controls.
// The hazard controller uses the slave modport and the pipeline uses the master modport.
interface pipe_hazard_ctl_if;
    logic [0:4] id_rs1;
    logic [0:4] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [0:4] ex_dest;
    logic       ex_reg_write;
    logic       ex_mem_to_reg;
    logic       ex_mul;
    logic       ex_branch_taken;
    logic       ex_leap;
    logic       mem_wait;

    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_stall;
    logic       idex_flush;
    logic       exmem_stall;
    logic       exmem_flush;
    logic       memwb_flush;
    logic [0:1] state;
    logic       mem_err;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_dest, ex_reg_write,
               ex_mem_to_reg, ex_mul, ex_branch_taken, ex_leap, mem_wait,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_flush, state, mem_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_dest, ex_reg_write,
               ex_mem_to_reg, ex_mul, ex_branch_taken, ex_leap, mem_wait,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_flush, state, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Central stall/flush sequencer for the five-stage pipeline: one prioritized decision
// (mem_wait, multiply, redirect, load-use) drives every hold/bubble control.
module pipe_hazard_ctl #(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input logic             clk,
    input logic             reset,
    pipe_hazard_ctl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 2);
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t     st, st_next, eff;
    logic [3:0] mcnt, mcnt_next;
    logic [7:0] wcnt, wcnt_next, wcnt_inc;
    logic       mul_active, mul_active_next;
    logic       err_q, err_next;
    logic       load_use, redirect;
    logic       pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c, idex_flush_c;
    logic       exmem_stall_c, exmem_flush_c, memwb_flush_c;

    assign load_use = hz.ex_mem_to_reg && hz.ex_reg_write && (hz.ex_dest != '0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_dest)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_dest)));
    assign redirect = hz.ex_branch_taken || hz.ex_leap;
    assign wcnt_inc = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;

    always_comb begin
        pc_stall_c      = 1'b0;
        ifid_stall_c    = 1'b0;
        ifid_flush_c    = 1'b0;
        idex_stall_c    = 1'b0;
        idex_flush_c    = 1'b0;
        exmem_stall_c   = 1'b0;
        exmem_flush_c   = 1'b0;
        memwb_flush_c   = 1'b0;
        st_next         = st;
        mcnt_next       = mcnt;
        wcnt_next       = wcnt;
        mul_active_next = mul_active;
        err_next        = err_q;

        // Leaving MEM_WAIT behaves exactly like the state the wait interrupted.
        eff = st;
        if (st == MEM_WAIT) begin
            eff = ((mcnt != 4'd0) || mul_active) ? MUL_WAIT : RUN;
        end

        if (hz.mem_wait) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            memwb_flush_c = 1'b1;
            st_next       = MEM_WAIT;
            wcnt_next     = wcnt_inc;
            if (wcnt_inc >= TIMEOUT) begin
                err_next = 1'b1;
            end
        end else begin
            wcnt_next = 8'd0;
            if (eff == MUL_WAIT) begin
                if (mcnt != 4'd0) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_stall_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                    mcnt_next     = mcnt - 4'd1;
                    st_next       = MUL_WAIT;
                end else begin
                    st_next         = RUN;
                    mul_active_next = 1'b0;
                end
            end else begin
                st_next = RUN;
                if (hz.ex_mul) begin
                    pc_stall_c      = 1'b1;
                    ifid_stall_c    = 1'b1;
                    idex_stall_c    = 1'b1;
                    exmem_flush_c   = 1'b1;
                    mcnt_next       = MUL_LOAD;
                    mul_active_next = 1'b1;
                    st_next         = MUL_WAIT;
                end else if (redirect) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= RUN;
            mcnt       <= 4'd0;
            wcnt       <= 8'd0;
            mul_active <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st         <= st_next;
            mcnt       <= mcnt_next;
            wcnt       <= wcnt_next;
            mul_active <= mul_active_next;
            err_q      <= err_next;
        end
    end

    // Controls are forced quiet while reset is held, whatever the inputs say.
    assign hz.pc_stall    = pc_stall_c    & ~reset;
    assign hz.ifid_stall  = ifid_stall_c  & ~reset;
    assign hz.ifid_flush  = ifid_flush_c  & ~reset;
    assign hz.idex_stall  = idex_stall_c  & ~reset;
    assign hz.idex_flush  = idex_flush_c  & ~reset;
    assign hz.exmem_stall = exmem_stall_c & ~reset;
    assign hz.exmem_flush = exmem_flush_c & ~reset;
    assign hz.memwb_flush = memwb_flush_c & ~reset;
    assign hz.state       = st;
    assign hz.mem_err     = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: expectations are queued when stimulus is driven
// and popped/compared at the following falling edge.
module tb_pipe_hazard_ctl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctl_if hz ();

    pipe_hazard_ctl #(
        .MUL_LAT    (4),
        .MEM_TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    // Bit order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic [7:0] MULS = 8'b1101_0010;
    localparam logic [7:0] MEMW = 8'b1101_0101;
    localparam logic [7:0] RED  = 8'b0010_1000;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        int         st;
        int         err;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ctlVec();
        return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                hz.idex_flush, hz.exmem_stall, hz.exmem_flush, hz.memwb_flush};
    endfunction

    task automatic clearInputs();
        hz.id_rs1          = '0;
        hz.id_rs2          = '0;
        hz.id_use_rs1      = 1'b0;
        hz.id_use_rs2      = 1'b0;
        hz.ex_dest         = '0;
        hz.ex_reg_write    = 1'b0;
        hz.ex_mem_to_reg   = 1'b0;
        hz.ex_mul          = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.ex_leap         = 1'b0;
        hz.mem_wait        = 1'b0;
    endtask

    task automatic setLoad(input logic [4:0] dest);
        hz.ex_mem_to_reg = 1'b1;
        hz.ex_reg_write  = 1'b1;
        hz.ex_dest       = dest;
    endtask

    task automatic popCompare();
        exp_t e;
        checkOutput("sb_depth", 16'(sb.size()), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, ".ctl"}, 16'(ctlVec()), 16'(e.ctl));
            if (e.st >= 0) checkOutput({e.tag, ".state"}, 16'(hz.state), 16'(e.st));
            if (e.err >= 0) checkOutput({e.tag, ".mem_err"}, 16'(hz.mem_err), 16'(e.err));
        end
    endtask

    // Inputs are already driven; one expectation per cycle, -1 means don't check that field.
    task automatic applyStimulus(input string tag, input logic [7:0] ctl, input int st, input int err);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.st  = st;
        e.err = err;
        sb.push_back(e);
        @(negedge clk);
        popCompare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clearInputs();
        hz.ex_mul   = 1'b1;
        hz.mem_wait = 1'b1;
        setLoad(5'd5);
        hz.id_use_rs2 = 1'b1;
        hz.id_rs2     = 5'd5;
        @(posedge clk);
        #1;
        applyStimulus("reset_hold", NONE, 0, 0);
        reset = 1'b0;
        clearInputs();
        applyStimulus("idle", NONE, 0, 0);

        // Load-use through rs2, then the bubble reaches EX
        setLoad(5'd5);
        hz.id_use_rs2 = 1'b1;
        hz.id_rs2     = 5'd5;
        applyStimulus("lu_rs2", LU, 0, -1);
        clearInputs();
        applyStimulus("lu_after", NONE, 0, -1);

        setLoad(5'd0);
        hz.id_use_rs2 = 1'b1;
        hz.id_rs2     = 5'd0;
        applyStimulus("lu_r0", NONE, 0, -1);

        clearInputs();
        setLoad(5'd17);
        hz.id_use_rs1 = 1'b1;
        hz.id_rs1     = 5'd17;
        applyStimulus("lu_rs1", LU, 0, -1);
        hz.id_use_rs1 = 1'b0;
        applyStimulus("lu_rs1_unused", NONE, 0, -1);
        hz.id_use_rs1   = 1'b1;
        hz.ex_reg_write = 1'b0;
        applyStimulus("lu_no_write", NONE, 0, -1);
        hz.ex_reg_write = 1'b1;
        hz.id_rs1       = 5'd16;
        applyStimulus("lu_other_reg", NONE, 0, -1);

        // Redirect overrides a simultaneous load-use
        hz.id_rs1          = 5'd17;
        hz.ex_branch_taken = 1'b1;
        applyStimulus("br_over_lu", RED, 0, -1);
        clearInputs();
        hz.ex_leap = 1'b1;
        applyStimulus("leap", RED, 0, -1);
        clearInputs();

        // Plain multiply, MUL_LAT=4
        hz.ex_mul = 1'b1;
        applyStimulus("mul0", MULS, 0, -1);
        applyStimulus("mul1", MULS, 1, -1);
        applyStimulus("mul2", MULS, 1, -1);
        applyStimulus("mul3", NONE, -1, -1);
        hz.ex_mul = 1'b0;
        applyStimulus("mul_done", NONE, 0, -1);

        // Memory wait during the second multiply cycle
        hz.ex_mul = 1'b1;
        applyStimulus("mw_mul0", MULS, 0, -1);
        hz.mem_wait = 1'b1;
        applyStimulus("mw_wait1", MEMW, 1, -1);
        applyStimulus("mw_wait2", MEMW, 2, -1);
        hz.mem_wait = 1'b0;
        applyStimulus("mw_res1", MULS, -1, -1);
        applyStimulus("mw_res2", MULS, 1, -1);
        applyStimulus("mw_res3", NONE, -1, -1);
        hz.ex_mul = 1'b0;
        applyStimulus("mw_done", NONE, 0, 0);

        // Memory wait from RUN alone
        hz.mem_wait = 1'b1;
        applyStimulus("mwr_wait", MEMW, 0, -1);
        hz.mem_wait = 1'b0;
        applyStimulus("mwr_exit", NONE, -1, -1);
        applyStimulus("mwr_run", NONE, 0, 0);

        // Timeout: mem_err sets on the 64th consecutive wait edge and is sticky
        hz.mem_wait = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus($sformatf("to_%0d", i), MEMW, (i == 0) ? 0 : 2, (i == 63) ? 0 : -1);
        end
        hz.mem_wait = 1'b0;
        applyStimulus("to_drop", NONE, -1, 1);
        applyStimulus("to_sticky", NONE, 0, 1);
        reset = 1'b1;
        applyStimulus("to_reset", NONE, 0, 0);
        reset = 1'b0;
        applyStimulus("to_after_reset", NONE, 0, 0);

        // Reset asserted mid-multiply aborts immediately
        hz.ex_mul = 1'b1;
        applyStimulus("rm_mul0", MULS, 0, -1);
        applyStimulus("rm_mul1", MULS, 1, -1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rm_async.ctl", 16'(ctlVec()), 16'(NONE));
        checkOutput("rm_async.state", 16'(hz.state), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        hz.ex_mul = 1'b0;
        applyStimulus("rm_after1", NONE, 0, 0);
        applyStimulus("rm_after2", NONE, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Central stall/flush sequencer for the five-stage pipeline. It drives the hold and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, multi-cycle multiply occupancy of EX, data-memory wait states, and control redirects from taken branches or leaps resolved in EX. All per-register controls come from one prioritized decision, so a register never sees stall and flush together.

## Interface

Parameters:
- MUL_LAT, 4, total EX cycles a multiply occupies; legal range 2..16.
- MEM_TIMEOUT, 64, consecutive mem_wait cycles before mem_err sets; legal range 1..255.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- id_rs1, id_rs2  input  [0:4]  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  input  1  the ID instruction actually reads the matching source.
- ex_dest  input  [0:4]  destination register of the instruction in EX.
- ex_reg_write  input  1  EX instruction writes ex_dest.
- ex_mem_to_reg  input  1  EX instruction is a load.
- ex_mul  input  1  EX instruction is a multi-cycle multiply.
- ex_branch_taken  input  1  taken branch resolved in EX.
- ex_leap  input  1  leap (jump) resolved in EX.
- mem_wait  input  1  data memory not ready this cycle.
- pc_stall  output  1  hold PC.
- ifid_stall, ifid_flush  output  1  hold / bubble IF/ID.
- idex_stall, idex_flush  output  1  hold / bubble ID/EX.
- exmem_stall, exmem_flush  output  1  hold / bubble EX/MEM.
- memwb_flush  output  1  bubble MEM/WB.
- state  output  [0:1]  0=RUN, 1=MUL_WAIT, 2=MEM_WAIT.
- mem_err  output  1  sticky memory-timeout flag.

## Operation

- Registered state: FSM state, multiply counter mcnt (4 bits), wait counter wcnt (8 bits, saturating), mem_err. All stall/flush outputs are combinational from state and inputs.
- Priority, highest first: reset, mem_wait, multiply, redirect, load-use.
- mem_wait=1 in any state:
  - Assert pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush. Deassert all other outputs.
  - Next state is MEM_WAIT. mcnt holds and the MUL context is retained.
  - wcnt increments. When wcnt reaches MEM_TIMEOUT, mem_err sets and stays set until reset.
- MEM_WAIT with mem_wait=0:
  - wcnt clears.
  - Return to MUL_WAIT if mcnt≠0 or a multiply was in progress; otherwise return to RUN.
  - Outputs for this cycle are evaluated as in the return state.
- RUN with ex_mul=1:
  - Assert pc_stall, ifid_stall, idex_stall, exmem_flush.
  - Load mcnt=MUL_LAT-2 and go to MUL_WAIT.
- MUL_WAIT with mcnt≠0: same four outputs; mcnt decrements.
- MUL_WAIT with mcnt=0: no stall or flush; go to RUN. ex_mul is ignored in MUL_WAIT, so the still-present multiply does not retrigger.
- RUN redirect (ex_branch_taken or ex_leap): assert ifid_flush and idex_flush. This overrides load-use.
- RUN load-use: hazard when ex_mem_to_reg & ex_reg_write & ex_dest≠0, and either (id_use_rs1 & id_rs1==ex_dest) or (id_use_rs2 & id_rs2==ex_dest). Response: pc_stall, ifid_stall, idex_flush for exactly one cycle.
- Register 0 never creates a hazard.

## Timing

- While reset is high: state=RUN, mcnt=0, wcnt=0, mem_err=0, and every stall/flush output is 0 regardless of inputs.
- Load-use costs exactly 1 bubble. Redirect costs 2 bubbles.
- A multiply with no memory waits holds the front end for MUL_LAT-1 cycles and inserts MUL_LAT-1 bubbles into EX/MEM.
- Each mem_wait cycle adds exactly one frozen cycle and is additive to multiply latency.
- Reset asserted mid-multiply or mid-wait aborts immediately. The first cycle after reset is RUN with counters clear.

## Test plan

- Load to r5 in EX, ID reads r5 via rs2 -> one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0. Same stimulus with ex_dest=0 -> no stall.
- ex_mul=1 with MUL_LAT=4 -> pc/ifid/idex stall and exmem_flush high for 3 cycles, state 0→1→1→0, 4th cycle clear.
- mem_wait pulsed 2 cycles during the 2nd multiply cycle -> full freeze plus memwb_flush for 2 cycles, state=2, multiply stall then resumes for its remaining 2 cycles.
- ex_branch_taken together with a load-use match -> only ifid_flush=idex_flush=1 for that cycle; no stall.
- mem_wait held 64 cycles with MEM_TIMEOUT=64 -> mem_err=1 after the 64th edge and stays 1 after mem_wait drops; reset clears it.
- Reset asserted mid-multiply -> all outputs 0 immediately, state=0; no residual stall after release.
